// File: rtl/demux_dispatcher_if.sv
// Handshake bundle: one producer stream in, NUM_OUT consumer channels out.
// slave = dispatcher side, master = producer/consumer side.
interface demux_dispatcher_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = 2
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;
  logic [WIDTH-1:0]   out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_dispatcher.sv
// Round-robin 1-to-N dispatcher with a one-entry hold register.
// Optional stall retarget enabled by macro DEMUX_TIMEOUT_EN.
module demux_dispatcher #(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = 2,
  parameter int SEL_W   = 1,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  demux_dispatcher_if.slave    bus,
  output logic [SEL_W-1:0]     cur_sel,
  output logic [15:0]          tx_count
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   hold_q;
  logic [NUM_OUT-1:0] sel_oh;
  logic [SEL_W-1:0]   sel_inc;
  logic               deliver;
  logic               accept;
  logic               retarget;

  // Decode pointer to a channel mask and compute its wrapped successor
  always_comb begin
    sel_oh  = NUM_OUT'(1) << cur_sel;
    sel_inc = (cur_sel == SEL_W'(NUM_OUT - 1)) ? '0 : cur_sel + 1'b1;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = '0;
    deliver       = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = HOLD;
      end
      HOLD: begin
        bus.out_valid = sel_oh;
        deliver       = |(bus.out_ready & sel_oh);
        bus.in_ready  = deliver;
        if (deliver && !bus.in_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept       = bus.in_valid & bus.in_ready;
  assign bus.out_data = hold_q;

`ifdef DEMUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] stall_q;

  assign retarget = (state == HOLD) && !deliver &&
                    (stall_q == CW'(TIMEOUT - 1));

  // Stall counter, cleared outside HOLD, on delivery and on retarget
  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (state != HOLD || deliver || retarget)
      stall_q <= '0;
    else
      stall_q <= stall_q + 1'b1;
  end
`else
  assign retarget = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Hold register captures only on an accepted handshake
  always_ff @(posedge clk) begin
    if (rst)         hold_q <= '0;
    else if (accept) hold_q <= bus.in_data;
  end

  // Pointer advances on delivery or retarget; count only deliveries
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_sel  <= '0;
      tx_count <= '0;
    end else if (deliver) begin
      cur_sel  <= sel_inc;
      tx_count <= tx_count + 16'd1;
    end else if (retarget) begin
      cur_sel  <= sel_inc;
    end
  end

endmodule

// File: doc/demux_dispatcher.md
Name: demux_dispatcher

Overview:
- Sequencing controller for the 1-to-N demultiplexer datapath.
- Accepts a single input stream under valid/ready handshake and holds each word in a one-entry register.
- Delivers each word to exactly one of NUM_OUT output channels in strict round-robin order, so the demux select is driven by the controller rather than the requester.
- Sits between a single producer and NUM_OUT consumers.

Parameters:
- WIDTH, 8, data word width.
- NUM_OUT, 2, number of output channels; legal range 2..(2**SEL_W).
- SEL_W, 1, width of the channel pointer; must satisfy NUM_OUT <= 2**SEL_W.
- TIMEOUT, 15, stall cycles before retarget; used only with DEMUX_TIMEOUT_EN.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, producer has a word.
- in_ready, output, 1, dispatcher accepts a word this cycle.
- in_data, input, WIDTH, producer word.
- out_valid, output, NUM_OUT, one-hot (or zero) per-channel valid.
- out_ready, input, NUM_OUT, per-channel consumer ready.
- out_data, output, WIDTH, held word, broadcast to all channels.
- cur_sel, output, SEL_W, channel targeted by the held word (HOLD) or the next word (IDLE).
- tx_count, output, 16, total words delivered; wraps at 65535 -> 0.

Behaviour:
- Reset values when rst=1 at an edge:
  - state=IDLE, out_valid=0, out_data=0, cur_sel=0, tx_count=0.
  - Held word discarded, stall counter=0.
  - in_ready is combinational and equals 1 in IDLE.
- FSM, two states:
  - IDLE: in_ready=1 and out_valid=0. If in_valid=1: capture in_data into the hold register, keep target=cur_sel, go to HOLD.
  - HOLD: out_valid[cur_sel]=1, all other out_valid bits 0, out_data=held word.
    - Delivery occurs when out_ready[cur_sel]=1. On delivery: tx_count+1, and cur_sel <- (cur_sel==NUM_OUT-1) ? 0 : cur_sel+1.
    - in_ready = out_ready[cur_sel] (combinational pass-through to allow back-to-back transfers).
    - Delivery and in_valid=1 in the same cycle: load the new word, stay in HOLD; the new word targets the advanced cur_sel.
    - Delivery with in_valid=0: go to IDLE.
    - No delivery: hold everything stable; out_data and cur_sel must not change.
- Latency:
  - A word accepted at edge t is presented on out_valid/out_data from cycle t+1.
  - Sustained throughput is 1 word/cycle when all consumers are ready.
- out_ready bits of non-targeted channels are ignored and never cause delivery.
- Wrap: with NUM_OUT=3, the sequence is 0,1,2,0,... Pointer values >= NUM_OUT are never produced.
- Producer must hold in_valid/in_data stable until in_ready=1; the dispatcher samples only on handshake.
- Reset mid-HOLD drops the held word (not counted); the next accepted word targets channel 0.
- Reset has priority over any simultaneous handshake.

Optional Feature:
- Macro DEMUX_TIMEOUT_EN.
- With the macro defined: a stall counter increments each HOLD cycle without delivery and clears on delivery or on entering HOLD. When it reaches TIMEOUT:
  - cur_sel advances (same wrap rule) and the counter clears.
  - The word stays held and is re-presented to the new channel the next cycle.
  - tx_count is unchanged.
- Without the macro: no counter; a held word waits indefinitely on its target channel.
- TIMEOUT has no effect when the macro is undefined.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release with in_valid=0 -> out_valid=00, in_ready=1, cur_sel=0, tx_count=0.
- Round-robin, NUM_OUT=2, both out_ready=1, in_data=A5,3C,FF,01 on consecutive cycles -> delivered to channels 0,1,0,1 one cycle after each accept; tx_count=4; no bubbles.
- Backpressure: out_ready=00 while holding 5A on ch0 for 5 cycles -> out_valid=01, out_data=5A stable, in_ready=0; raising out_ready[1] alone causes no delivery; raising out_ready[0] delivers, cur_sel=1.
- Wrap, NUM_OUT=3, SEL_W=2: 7 words, all consumers ready -> channels 0,1,2,0,1,2,0; cur_sel never reads 3.
- Reset mid-HOLD: hold 77 on ch1, assert rst for one cycle -> out_valid=000, tx_count=0, next word 11 goes to ch0.
- DEMUX_TIMEOUT_EN, TIMEOUT=4: ch0 never ready, ch1 ready -> word C3 retargeted to ch1 after 4 stall cycles, delivered there; tx_count=1.
